alu_cmd_sequencer: RTL and testbench

Command-queue controller that sequences the 8-bit accumulator ALU datapath. Requesters push opcode/operand commands into a small internal FIFO. The controller pops one command at a time and drives the ALU input-selector (persist/load/reset), output-selector (one-hot op) and operand. It then captures the ALU result/overflow and returns a response. It owns the off/ready/run/run_error state machine for the ALU.

---
 rtl/alu_cmd_sequencer_if.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command/ALU/response bundle for alu_cmd_sequencer.
// master: requester + ALU side. slave: the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_operand;
  logic [2:0]       alu_in_sel;
  logic [6:0]       alu_out_sel;
  logic [WIDTH-1:0] alu_num;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_error;
  logic [1:0]       state;
  logic [CW-1:0]    fifo_count;

  modport master (
    output cmd_valid, cmd_op, cmd_operand, alu_result, alu_overflow,
    input  cmd_ready, alu_in_sel, alu_out_sel, alu_num,
           rsp_valid, rsp_data, rsp_error, state, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, alu_result, alu_overflow,
    output cmd_ready, alu_in_sel, alu_out_sel, alu_num,
           rsp_valid, rsp_data, rsp_error, state, fifo_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-queue controller for the accumulator ALU: buffers commands in a
// small FIFO, issues one at a time, captures result/overflow, responds.
// Optional build macro ALU_SEQ_STICKY_ERR_EN makes S_RUN_ERROR sticky
// until on drops (or reset).
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LAT   = 1
)(
  input logic clk,
  input logic rst,
  input logic on,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [2:0] OP_CLEAR    = 3'd7;
  localparam logic [2:0] SEL_PERSIST = 3'b100;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b001;

  typedef enum logic [1:0] {
    S_OFF       = 2'b00,
    S_READY     = 2'b01,
    S_RUN       = 2'b10,
    S_RUN_ERROR = 2'b11
  } state_t;

  state_t           state, nextState;
  logic [2:0]       opMem  [DEPTH];
  logic [WIDTH-1:0] numMem [DEPTH];
  logic [AW-1:0]    wrPtr, rdPtr;
  logic [CW-1:0]    count;
  logic [2:0]       curOp;
  logic [NW-1:0]    runCnt;
  logic [6:0]       outSelReg;
  logic [WIDTH-1:0] numReg, rspDataReg;
  logic             rspValidReg, rspErrorReg;
  logic [2:0]       inSel;
  logic             ready, push, pop, sample, toError, flush;

  // Acceptance uses the registered count only; a pop never frees a slot
  // in the same cycle.
  always_comb begin
    ready = (state != S_OFF) && (count != CW'(DEPTH));
`ifdef ALU_SEQ_STICKY_ERR_EN
    if (state == S_RUN_ERROR) ready = 1'b0;
`endif
  end

  assign push = bus.cmd_valid & ready;

  // Next-state, pop/sample strobes and ALU input select.
  always_comb begin
    nextState = state;
    pop       = 1'b0;
    sample    = 1'b0;
    toError   = 1'b0;
    inSel     = SEL_RESET;
    case (state)
      S_OFF: begin
        inSel = SEL_RESET;
        if (on) nextState = S_READY;
      end
      S_READY: begin
        inSel = SEL_PERSIST;
        if (!on) nextState = S_OFF;
        else if (count != '0) begin
          pop       = 1'b1;
          nextState = S_RUN;
        end
      end
      S_RUN: begin
        if (runCnt == '0) inSel = (curOp == OP_CLEAR) ? SEL_RESET : SEL_LOAD;
        else              inSel = SEL_PERSIST;
        if (runCnt == NW'(LAT - 1)) begin
          sample    = 1'b1;
          toError   = bus.alu_overflow && (curOp != OP_CLEAR);
          nextState = toError ? S_RUN_ERROR : S_READY;
        end
      end
      S_RUN_ERROR: begin
        inSel = SEL_RESET;
`ifdef ALU_SEQ_STICKY_ERR_EN
        if (!on) nextState = S_OFF;
`else
        nextState = S_READY;
`endif
      end
      default: nextState = S_OFF;
    endcase
  end

  // Going to S_OFF drops whatever is still queued.
  assign flush = (nextState == S_OFF);

  // State register, FIFO, issue registers and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_OFF;
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      curOp       <= '0;
      runCnt      <= '0;
      outSelReg   <= '0;
      numReg      <= '0;
      rspValidReg <= 1'b0;
      rspDataReg  <= '0;
      rspErrorReg <= 1'b0;
    end else begin
      state <= nextState;

      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          opMem[wrPtr]  <= bus.cmd_op;
          numMem[wrPtr] <= bus.cmd_operand;
          wrPtr         <= wrPtr + AW'(1);
        end
        if (pop) rdPtr <= rdPtr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end

      if (pop) begin
        curOp     <= opMem[rdPtr];
        numReg    <= numMem[rdPtr];
        outSelReg <= (opMem[rdPtr] == OP_CLEAR) ? 7'b0 : (7'b1000000 >> opMem[rdPtr]);
        runCnt    <= '0;
      end else if (state == S_RUN) begin
        runCnt <= runCnt + NW'(1);
      end

      rspValidReg <= 1'b0;
      if (sample) begin
        rspValidReg <= 1'b1;
        rspErrorReg <= toError;
        rspDataReg  <= (curOp == OP_CLEAR) ? '0 : bus.alu_result;
      end
    end
  end

  assign bus.cmd_ready   = ready;
  assign bus.alu_in_sel  = inSel;
  assign bus.alu_out_sel = outSelReg;
  assign bus.alu_num     = numReg;
  assign bus.rsp_valid   = rspValidReg;
  assign bus.rsp_data    = rspDataReg;
  assign bus.rsp_error   = rspErrorReg;
  assign bus.state       = state;
  assign bus.fifo_count  = count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: an accumulator ALU stub plus scenario tasks
// and a randomized run checked against an op-level reference model.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic on  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_cmd_sequencer_if #(.WIDTH(8), .DEPTH(4)) bus();

  alu_cmd_sequencer #(.WIDTH(8), .DEPTH(4), .LAT(1)) dut (
    .clk(clk), .rst(rst), .on(on), .bus(bus)
  );

  always #5 clk = ~clk;

  // Accumulator ALU stub driven by the sequencer's selects.
  logic [7:0]  acc;
  logic [15:0] wide;
  logic        ovf;
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (bus.alu_out_sel)
      7'b1000000: wide = {8'h0, acc & bus.alu_num};
      7'b0100000: wide = {8'h0, acc | bus.alu_num};
      7'b0010000: wide = {8'h0, ~acc};
      7'b0001000: wide = {8'h0, acc ^ bus.alu_num};
      7'b0000100: begin wide = 16'(acc) + 16'(bus.alu_num); ovf = wide[8]; end
      7'b0000010: begin wide = {8'h0, acc - bus.alu_num}; ovf = (acc < bus.alu_num); end
      7'b0000001: begin wide = 16'(acc) * 16'(bus.alu_num); ovf = |wide[15:8]; end
      default:    wide = '0;
    endcase
    bus.alu_result   = wide[7:0];
    bus.alu_overflow = ovf;
  end

  // In-sel: load captures the result, reset clears, persist holds.
  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else if (bus.alu_in_sel == 3'b010) acc <= wide[7:0];
    else if (bus.alu_in_sel == 3'b001) acc <= '0;
  end

  // Response and issue monitors.
  logic [8:0]  rspQ[$];
  logic [17:0] selQ[$];
  logic        prevRun = 1'b0;
  always @(negedge clk) begin
    if (bus.rsp_valid) rspQ.push_back({bus.rsp_error, bus.rsp_data});
    if (bus.state == 2'b10 && !prevRun) selQ.push_back({bus.alu_in_sel, bus.alu_out_sel, bus.alu_num});
    prevRun <= (bus.state == 2'b10);
  end

  logic [6:0] selTbl [0:6] = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000,
                               7'b0000100, 7'b0000010, 7'b0000001};

  // Reference: one command applied to an accumulator value -> {overflow, result}.
  function automatic logic [8:0] refStep(input int op, input int a, input int b);
    int r;
    logic ov;
    ov = 1'b0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = (~a) & 255;
      3: r = a ^ b;
      4: begin r = a + b; ov = (r > 255); end
      5: begin r = a - b; ov = (r < 0);   end
      6: begin r = a * b; ov = (r > 255); end
      default: r = 0;
    endcase
    return {ov, 8'(r)};
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset(input logic onVal);
    @(negedge clk);
    rst = 1'b1; on = onVal;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_operand = '0;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(1);
  endtask

  // Offer one command and hold it until accepted (call away from the edge).
  task automatic pushCmd(input int op, input int num);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'(op); bus.cmd_operand = 8'(num);
    while (!bus.cmd_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready stayed %b, required 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; on = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_operand = 8'h5A;
    waitCycles(2);
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", bus.state); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.alu_in_sel !== 3'b001) begin errors++; $display("FAIL reset_insel: got %b want 001", bus.alu_in_sel); end
    checks++; if (bus.alu_out_sel !== 7'b0) begin errors++; $display("FAIL reset_outsel: got %b want 0", bus.alu_out_sel); end
    checks++; if (bus.alu_num !== 8'h0) begin errors++; $display("FAIL reset_num: got %h want 00", bus.alu_num); end
    checks++; if ({bus.rsp_valid, bus.rsp_error, bus.rsp_data} !== 10'h0) begin
      errors++; $display("FAIL reset_rsp: got v%b e%b d%h want all 0", bus.rsp_valid, bus.rsp_error, bus.rsp_data);
    end
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    doReset(1'b1);
    rspQ.delete();
    pushCmd(4, 5);
    @(negedge clk);
    checks++; if (bus.state !== 2'b01 || bus.fifo_count !== 3'd1) begin
      errors++; $display("FAIL basic_queued: got st%b cnt%0d want st01 cnt1", bus.state, bus.fifo_count);
    end
    @(negedge clk);
    checks++; if ({bus.state, bus.alu_in_sel, bus.alu_out_sel, bus.alu_num} !== {2'b10, 3'b010, 7'b0000100, 8'd5}) begin
      errors++; $display("FAIL basic_issue: got st%b in%b out%b num%h want st10 in010 out0000100 num05",
                         bus.state, bus.alu_in_sel, bus.alu_out_sel, bus.alu_num);
    end
    @(negedge clk);
    checks++; if ({bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data} !== {2'b01, 1'b1, 1'b0, 8'd5}) begin
      errors++; $display("FAIL basic_rsp1: got st%b v%b e%b d%h want st01 v1 e0 d05",
                         bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data);
    end
    pushCmd(4, 3);
    waitCycles(5);
    checks++; if (rspQ.size() != 2) begin errors++; $display("FAIL basic_pulses: got %0d want 2", rspQ.size()); end
    else begin
      checks++; if (rspQ[1] !== {1'b0, 8'd8}) begin errors++; $display("FAIL basic_rsp2: got %h want 008", rspQ[1]); end
    end
  endtask

  task automatic test_backpressure;
    int accepted = 0;
    int guard = 0;
    bit sawFull = 0;
    doReset(1'b0);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_operand = 8'd1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b0 || bus.fifo_count !== 3'd0) begin
        errors++; $display("FAIL off_reject: got rdy%b cnt%0d want rdy0 cnt0", bus.cmd_ready, bus.fifo_count);
      end
    end
    on = 1'b1;
    rspQ.delete();
    while (accepted < 10 && guard < 100) begin
      @(negedge clk); guard++;
      checks++; if (bus.fifo_count > 3'd4) begin errors++; $display("FAIL bp_overfill: got %0d max 4", bus.fifo_count); end
      if (bus.state != 2'b00) begin
        checks++; if (bus.cmd_ready !== (bus.fifo_count != 3'd4)) begin
          errors++; $display("FAIL bp_ready: got %b with count %0d", bus.cmd_ready, bus.fifo_count);
        end
      end
      if (bus.fifo_count == 3'd4) sawFull = 1;
      if (bus.cmd_ready) accepted++;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if (!sawFull) begin errors++; $display("FAIL bp_full_seen: got 0 want 1"); end
    waitCycles(30);
    checks++; if (rspQ.size() != 10) begin errors++; $display("FAIL bp_rsp_count: got %0d want 10", rspQ.size()); end
    else for (int i = 0; i < 10; i++) begin
      checks++; if (rspQ[i] !== {1'b0, 8'(i + 1)}) begin errors++; $display("FAIL bp_rsp%0d: got %h want %h", i, rspQ[i], i + 1); end
    end
  endtask

  task automatic test_overflow;
    doReset(1'b1);
    pushCmd(7, 0);
    pushCmd(1, 8'h10);
    waitCycles(6);
    rspQ.delete();
    pushCmd(6, 8'h20);
    waitCycles(2);
    checks++; if (bus.state !== 2'b10) begin errors++; $display("FAIL ovf_run: got %b want 10", bus.state); end
    @(negedge clk);
    checks++; if ({bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data, bus.alu_in_sel} !== {2'b11, 1'b1, 1'b1, 8'h00, 3'b001}) begin
      errors++; $display("FAIL ovf_err: got st%b v%b e%b d%h in%b want st11 v1 e1 d00 in001",
                         bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data, bus.alu_in_sel);
    end
    @(negedge clk);
`ifdef ALU_SEQ_STICKY_ERR_EN
    checks++; if ({bus.state, bus.rsp_valid, bus.cmd_ready, bus.alu_in_sel} !== {2'b11, 1'b0, 1'b0, 3'b001}) begin
      errors++; $display("FAIL ovf_sticky: got st%b v%b rdy%b in%b want st11 v0 rdy0 in001",
                         bus.state, bus.rsp_valid, bus.cmd_ready, bus.alu_in_sel);
    end
    on = 1'b0;
    @(negedge clk);
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL ovf_sticky_off: got %b want 00", bus.state); end
    on = 1'b1;
    @(negedge clk);
`else
    checks++; if (bus.state !== 2'b01 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_recover: got st%b v%b want st01 v0", bus.state, bus.rsp_valid);
    end
`endif
    pushCmd(4, 7);
    waitCycles(4);
    checks++; if (rspQ.size() != 2 || rspQ[$] !== {1'b0, 8'd7}) begin
      errors++; $display("FAIL ovf_after: got n%0d last %h want n2 last 007", rspQ.size(), rspQ[$]);
    end
  endtask

  task automatic test_clear;
    doReset(1'b1);
    rspQ.delete();
    pushCmd(7, 0);
    pushCmd(1, 8'hAA);
    waitCycles(6);
    checks++; if (rspQ.size() != 2 || rspQ[$] !== {1'b0, 8'hAA}) begin
      errors++; $display("FAIL clr_setup: got n%0d last %h want n2 last 0aa", rspQ.size(), rspQ[$]);
    end
    pushCmd(7, 8'h55);
    waitCycles(2);
    checks++; if ({bus.state, bus.alu_in_sel, bus.alu_out_sel} !== {2'b10, 3'b001, 7'b0}) begin
      errors++; $display("FAIL clr_issue: got st%b in%b out%b want st10 in001 out0", bus.state, bus.alu_in_sel, bus.alu_out_sel);
    end
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_error, bus.rsp_data} !== {1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL clr_rsp: got v%b e%b d%h want v1 e0 d00", bus.rsp_valid, bus.rsp_error, bus.rsp_data);
    end
  endtask

  task automatic test_rst_mid;
    int guard = 0;
    doReset(1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_operand = 8'd1;
    do begin @(negedge clk); guard++; end
    while (!(bus.state == 2'b10 && bus.fifo_count >= 3'd3) && guard < 40);
    checks++; if (guard >= 40) begin errors++; $display("FAIL rstmid_setup: got cnt%0d want >=3 in run", bus.fifo_count); end
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.state, bus.fifo_count, bus.rsp_valid} !== {2'b00, 3'd0, 1'b0}) begin
      errors++; $display("FAIL rstmid: got st%b cnt%0d v%b want st00 cnt0 v0", bus.state, bus.fifo_count, bus.rsp_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_on_drop;
    int guard = 0;
    int done;
    doReset(1'b1);
    rspQ.delete();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_operand = 8'd1;
    do begin @(negedge clk); guard++; end
    while (!(bus.state == 2'b10 && bus.fifo_count >= 3'd2) && guard < 40);
    checks++; if (guard >= 40) begin errors++; $display("FAIL ondrop_setup: got cnt%0d want >=2 in run", bus.fifo_count); end
    done = rspQ.size();
    on = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if ({bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data} !== {2'b01, 1'b1, 1'b0, 8'(done + 1)}) begin
      errors++; $display("FAIL ondrop_rsp: got st%b v%b e%b d%h want st01 v1 e0 d%h",
                         bus.state, bus.rsp_valid, bus.rsp_error, bus.rsp_data, done + 1);
    end
    @(negedge clk);
    checks++; if (bus.state !== 2'b00 || bus.fifo_count !== 3'd0) begin
      errors++; $display("FAIL ondrop_off: got st%b cnt%0d want st00 cnt0", bus.state, bus.fifo_count);
    end
    on = 1'b1;
  endtask

  task automatic test_op_sweep;
    doReset(1'b1);
    for (int op = 0; op < 7; op++) begin
      pushCmd(op, 0);
      waitCycles(2);
      checks++; if (bus.alu_out_sel !== selTbl[op]) begin
        errors++; $display("FAIL sweep_op%0d: got %b want %b", op, bus.alu_out_sel, selTbl[op]);
      end
      waitCycles(3);
    end
  endtask

  task automatic test_random;
    int ops[$];
    int nums[$];
    int refAcc = 0;
    int guard = 0;
    int op;
    logic [8:0] r;
    logic expErr;
    doReset(1'b1);
    rspQ.delete();
    selQ.delete();
    for (int i = 0; i < 30; i++) begin
`ifdef ALU_SEQ_STICKY_ERR_EN
      case ($urandom_range(0, 4))
        0: op = 0;
        1: op = 1;
        2: op = 2;
        3: op = 3;
        default: op = 7;
      endcase
`else
      op = int'($urandom_range(0, 7));
`endif
      ops.push_back(op);
      nums.push_back(int'($urandom_range(0, 255)));
      pushCmd(op, nums[i]);
      if ($urandom_range(0, 3) == 0) waitCycles(int'($urandom_range(1, 3)));
    end
    while (rspQ.size() < 30 && guard < 400) begin @(negedge clk); guard++; end
    checks++; if (rspQ.size() != 30 || selQ.size() != 30) begin
      errors++; $display("FAIL rand_count: got rsp%0d iss%0d want 30", rspQ.size(), selQ.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        r = refStep(ops[i], refAcc, nums[i]);
        expErr = r[8] && (ops[i] != 7);
        refAcc = expErr ? 0 : int'(r[7:0]);
        checks++; if (rspQ[i] !== {expErr, r[7:0]}) begin
          errors++; $display("FAIL rand_rsp%0d op%0d: got %h want %h", i, ops[i], rspQ[i], {expErr, r[7:0]});
        end
        checks++; if (selQ[i] !== {(ops[i] == 7) ? 3'b001 : 3'b010, (ops[i] == 7) ? 7'b0 : selTbl[ops[i]], 8'(nums[i])}) begin
          errors++; $display("FAIL rand_issue%0d op%0d: got %h", i, ops[i], selQ[i]);
        end
      end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_operand = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_clear();
    test_rst_mid();
    test_on_drop();
    test_op_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
